dehaze_recover: RTL
===================

# dehaze_recover

Recovers the haze-free pixel J = A + (I − A)·inv_t for each RGB pixel, consuming the inv_t stream (Q4.8) produced by the transmission-estimate stage. Input pixels arrive earlier than their inv_t, so the block buffers them in a small FIFO and pops one pixel per accepted inv_t. It sits at the tail of the dehaze pipeline, just before the output formatter.

## Interface
Parameters:
- DEPTH, 8: pixel FIFO depth; power of two, ≥ 2.
- AW, $clog2(DEPTH): FIFO address width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush of FIFO, pipeline valids and flags.
- atmo_a  in  24  atmospheric light {R,G,B}, 8b each; quasi-static, sampled with each popped pixel.
- pix_in  in  24  input pixel {R[23:16],G[15:8],B[7:0]}.
- pix_valid  in  1  pix_in valid this cycle.
- inv_t  in  12  1/t, unsigned Q4.8.
- inv_valid  in  1  inv_t valid this cycle.
- out_pix  out  24  recovered pixel, same packing.
- out_valid  out  1  one-cycle strobe per recovered pixel.
- fifo_level  out  AW+1  pixels currently buffered.
- ovf  out  1  sticky: a pixel was dropped because the FIFO was full.
- unf  out  1  sticky: an inv_t arrived with the FIFO empty.

## Operation
- Push: pix_valid && (!full || pop this cycle) writes pix_in. pix_valid && full && !pop drops the pixel and sets ovf.
- Pop: inv_valid && !empty reads the head pixel. inv_valid && empty discards inv_t, sets unf, produces no output. There is no bypass: on an empty FIFO with simultaneous push and inv_valid, the pixel is pushed (level→1) and inv_t is discarded.
- Simultaneous push and pop on a full FIFO: both accepted, level unchanged.
- Per channel c: diff = I_c − A_c (signed 9b); prod = diff·inv_t (signed 22b, 8 fractional bits); rnd = (prod + 128) >>> 8 (arithmetic, floor after +0.5); sum = A_c + rnd; out_c = sum<0 ? 0 : sum>255 ? 255 : sum.
- Pipeline is non-stallable; there is no backpressure on either input.
- clr: level←0, read/write pointers←0, ovf/unf←0, all in-flight pipeline valids←0; out_pix holds its value. clr has priority over push/pop in the same cycle.
- Reset: out_pix=0, out_valid=0, fifo_level=0, ovf=0, unf=0, pointers 0.

## Timing
- S1: popped pixel, atmo_a and inv_t registered.
- S2: the three diffs and products registered.
- S3: round, add, saturate, registered to out_pix/out_valid.
- Latency: an inv_valid sampled at edge k with a non-empty FIFO gives out_valid=1 during cycle k+3 (after edge k+3).
- Throughput: one pixel per cycle.
- fifo_level updates at the edge that performs push/pop.
- ovf/unf assert at the edge after the offending cycle and stay high until clr or reset.
- Reset asserted mid-stream: all state clears asynchronously and in-flight results are lost; out_valid stays low until new inv_t strobes complete the full 3-cycle latency.

## Structure
- dehaze_pkg: PIX_W=8, INV_T_W=12, INV_T_FRAC=8, RGB pack/unpack helpers, saturate-to-u8 function. Shared with the transmission stage.
- Sub-module sync_fifo (parameterised width/depth, level output, full/empty, simultaneous push/pop). Instantiate it with width 24.
- Three per-channel datapath lanes use a generate loop inside dehaze_recover.

## Test plan
- A=(200,200,200); push I=(100,150,250); inv_t=0x200 → out_pix=(0,100,255), exactly 3 cycles after inv_valid.
- inv_t=0x100 with 8 random pixels pushed back-to-back, inv_t streamed 5 cycles later → out_pix equals inputs in order, fifo_level peaks at 5.
- Rounding: A=200, I=201, inv_t=0x180 → 202; I=199, inv_t=0x180 → 199.
- Push 9 pixels with DEPTH=8 and no pop → 9th dropped, ovf=1, level=8; then push+pop in the same cycle while full → level stays 8, no further ovf.
- inv_valid with empty FIFO → unf=1, no out_valid; simultaneous push plus inv_valid on empty → level=1, no output.
- clr mid-stream with 2 results in flight → no out_valid afterwards, level=0, flags=0; async rst_n mid-stream → all outputs 0.

Source files
------------

// File: rtl/dehaze_pkg.sv
// Shared dehaze pipeline definitions: pixel/transmission widths, RGB packing helpers,
// and the u8 saturation used by the transmission and recovery stages.
package dehaze_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned INV_T_W    = 12;
  localparam int unsigned INV_T_FRAC = 8;
  localparam int unsigned RGB_W      = 3 * PIX_W;

  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } ch_e;

  function automatic logic [PIX_W-1:0] rgb_get(input logic [RGB_W-1:0] p, input int unsigned c);
    return p[c*PIX_W +: PIX_W];
  endfunction

  function automatic logic [RGB_W-1:0] rgb_pack(input logic [PIX_W-1:0] r,
                                                input logic [PIX_W-1:0] g,
                                                input logic [PIX_W-1:0] b);
    return {r, g, b};
  endfunction

  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [21:0] v);
    if (v < 0)
      return '0;
    else if (v > 22'sd255)
      return '1;
    else
      return v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level output and registered read data; a pop on a full
// FIFO frees the slot so a simultaneous push is accepted.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dehaze_recover.sv
// Haze-free recovery J = A + (I - A) * inv_t per RGB channel; pixels wait in a FIFO
// until their inv_t arrives, then flow through a 3-stage non-stallable datapath.
module dehaze_recover
  import dehaze_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [RGB_W-1:0]   atmo_a,
  input  logic [RGB_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic [INV_T_W-1:0] inv_t,
  input  logic               inv_valid,
  output logic [RGB_W-1:0]   out_pix,
  output logic               out_valid,
  output logic [AW:0]        fifo_level,
  output logic               ovf,
  output logic               unf
);

  localparam logic signed [21:0] RND = 22'sd1 <<< (INV_T_FRAC - 1);

  logic [RGB_W-1:0]   head;
  logic               full;
  logic               empty;
  logic               s0_vld, s1_vld, s2_vld;
  logic [INV_T_W-1:0] s0_inv, s1_inv;
  logic [RGB_W-1:0]   s1_pix, s1_a;
  logic [PIX_W-1:0]   lane_sat [3];

  sync_fifo #(
    .WIDTH (RGB_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (pix_valid),
    .pop   (inv_valid),
    .din   (pix_in),
    .dout  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // The FIFO read is registered, so inv_t is held one cycle (s0) to meet its pixel in S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld    <= 1'b0;
      s0_inv    <= '0;
      s1_vld    <= 1'b0;
      s1_inv    <= '0;
      s1_pix    <= '0;
      s1_a      <= '0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (clr) begin
      s0_vld    <= 1'b0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      // A full FIFO is never empty, so a pop happens exactly when inv_valid is high.
      ovf       <= ovf | (pix_valid && full && !inv_valid);
      unf       <= unf | (inv_valid && empty);
      s0_vld    <= inv_valid && !empty;
      s0_inv    <= inv_t;
      s1_vld    <= s0_vld;
      s1_inv    <= s0_inv;
      s1_pix    <= head;
      s1_a      <= atmo_a;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      if (s2_vld)
        out_pix <= rgb_pack(lane_sat[2], lane_sat[1], lane_sat[0]);
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_lane
    logic signed [8:0]  diff;
    logic signed [21:0] prod_d;
    logic signed [21:0] prod_q;
    logic signed [21:0] sum;
    logic [PIX_W-1:0]   a_q;

    always_comb begin
      diff   = $signed({1'b0, rgb_get(s1_pix, c)}) - $signed({1'b0, rgb_get(s1_a, c)});
      prod_d = $signed({{13{diff[8]}}, diff}) * $signed({10'b0, s1_inv});
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        a_q    <= '0;
      end else begin
        prod_q <= prod_d;
        a_q    <= rgb_get(s1_a, c);
      end
    end

    assign sum         = $signed({14'b0, a_q}) + ((prod_q + RND) >>> INV_T_FRAC);
    assign lane_sat[c] = sat_u8(sum);
  end

endmodule
